// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
//   state_t  - fetch FSM states
//   if_id_t  - contents of the IF/ID pipeline register
//   is_two_word() - first-word decode for two-word instructions
package fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 32;

    // Top two opcode bits set marks a two-word instruction.
    localparam logic [INSTR_W-1:0] TWO_WORD_MASK = 16'hC000;
    localparam logic [INSTR_W-1:0] TWO_WORD_VAL  = 16'hC000;

    typedef enum logic [2:0] {
        RESET  = 3'd0,
        VEC_HI = 3'd1,
        VEC_LO = 3'd2,
        FETCH  = 3'd3,
        IMM    = 3'd4
    } state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] imm;
        logic [ADDR_W-1:0]  pc;
        logic               valid;
    } if_id_t;

    function automatic logic is_two_word(input logic [INSTR_W-1:0] w);
        return (w & TWO_WORD_MASK) == TWO_WORD_VAL;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst - clock, synchronous active-high reset (clears everything)
//   clear    - drop valid only (bubble); payload fields are left as-is
//   load     - capture d and mark valid
//   neither  - hold
//   d / q    - register input / output
module if_id_reg
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   clear,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q.valid <= 1'b0;
        end else if (load) begin
            q       <= d;
            q.valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch stage controller. Loads the PC from a two-half-word reset
// vector, fetches one- and two-word instructions from a combinational-read
// instruction memory and fills the IF/ID register for decode.
//   clk, rst            - clock, synchronous active-high reset
//   stall               - hold PC, state, hold regs and IF/ID
//   redirect/redirect_pc- load a new PC and inject a bubble
//   mem_*               - instruction memory port (read-only, write tied 0)
//   if_id_*             - IF/ID register outputs
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RST_VEC_ADDR = 32'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_cs,
    output logic [INSTR_W-1:0] mem_wdata,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [INSTR_W-1:0] if_id_imm,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic               if_id_valid
);

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] hold_instr;
    logic [ADDR_W-1:0]  hold_pc;

    logic   two_word;
    logic   run;          // fetch states, no redirect, no stall
    logic   ifid_load;
    logic   ifid_clear;
    if_id_t ifid_d;
    if_id_t ifid_q;

    assign two_word = is_two_word(mem_rdata);
    assign run      = ((state == FETCH) || (state == IMM)) && !redirect && !stall;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= RESET;
        else     state <= state_nxt;
    end

    // Next state; redirect wins over stall in the fetch states
    always_comb begin
        state_nxt = state;
        case (state)
            RESET:  state_nxt = VEC_HI;
            VEC_HI: state_nxt = VEC_LO;
            VEC_LO: state_nxt = FETCH;
            FETCH: begin
                if (redirect)      state_nxt = FETCH;
                else if (stall)    state_nxt = FETCH;
                else if (two_word) state_nxt = IMM;
                else               state_nxt = FETCH;
            end
            IMM: begin
                if (redirect)   state_nxt = FETCH;
                else if (stall) state_nxt = IMM;
                else            state_nxt = FETCH;
            end
            default: state_nxt = RESET;
        endcase
    end

    // Outputs: memory port and IF/ID controls
    always_comb begin
        mem_cs     = (state != RESET);
        mem_read   = (state != RESET);
        mem_write  = 1'b0;
        mem_wdata  = '0;
        ifid_load  = 1'b0;
        ifid_clear = 1'b0;
        ifid_d     = '0;
        case (state)
            RESET:   mem_addr = '0;
            VEC_HI:  mem_addr = RST_VEC_ADDR;
            VEC_LO:  mem_addr = RST_VEC_ADDR + 32'd1;
            default: mem_addr = pc;
        endcase
        if ((state == FETCH) || (state == IMM)) begin
            if (redirect) begin
                ifid_clear = 1'b1;
            end else if (!stall) begin
                if (state == IMM) begin
                    ifid_load    = 1'b1;
                    ifid_d.instr = hold_instr;
                    ifid_d.imm   = mem_rdata;
                    ifid_d.pc    = hold_pc;
                end else if (two_word) begin
                    // first half of a two-word instruction: bubble this cycle
                    ifid_clear = 1'b1;
                end else begin
                    ifid_load    = 1'b1;
                    ifid_d.instr = mem_rdata;
                    ifid_d.pc    = pc;
                end
            end
        end
    end

    // PC and two-word hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= '0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else begin
            case (state)
                VEC_HI: pc[31:16] <= mem_rdata;
                VEC_LO: pc[15:0]  <= mem_rdata;
                FETCH, IMM: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end else if (run) begin
                        pc <= pc + 32'd1;   // wraps naturally at 2^32
                        if ((state == FETCH) && two_word) begin
                            hold_instr <= mem_rdata;
                            hold_pc    <= pc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    if_id_reg u_if_id (
        .clk   (clk),
        .rst   (rst),
        .load  (ifid_load),
        .clear (ifid_clear),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign if_id_instr = ifid_q.instr;
    assign if_id_imm   = ifid_q.imm;
    assign if_id_pc    = ifid_q.pc;
    assign if_id_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mem_addr;
    logic        mem_read, mem_write, mem_cs;
    logic [15:0] mem_wdata, mem_rdata;
    logic [15:0] if_id_instr, if_id_imm;
    logic [31:0] if_id_pc;
    logic        if_id_valid;

    logic [15:0] mem [256];
    assign mem_rdata = mem[mem_addr[7:0]];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_cs(mem_cs), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .if_id_instr(if_id_instr), .if_id_imm(if_id_imm),
        .if_id_pc(if_id_pc), .if_id_valid(if_id_valid)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // one clock edge, then sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".cs"},    32'(mem_cs), 0);
        chk({tag, ".rd"},    32'(mem_read), 0);
        chk({tag, ".addr"},  mem_addr, 0);
        chk({tag, ".instr"}, 32'(if_id_instr), 0);
        chk({tag, ".imm"},   32'(if_id_imm), 0);
        chk({tag, ".pc"},    if_id_pc, 0);
        chk({tag, ".valid"}, 32'(if_id_valid), 0);
    endtask

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        cs;      // expected mem_cs/mem_read before the edge
        logic [31:0] addr;    // expected mem_addr before the edge
        logic        full;    // also check payload after the edge
        logic [15:0] instr;
        logic [15:0] imm;
        logic [31:0] pc;
        logic        valid;
    } vec_t;

    vec_t vecs [16];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h0000; mem[8'h01] = 16'h0020;
        mem[8'h20] = 16'h1940; mem[8'h21] = 16'hC800; mem[8'h22] = 16'h1234;
        mem[8'h23] = 16'h2001; mem[8'h24] = 16'h2002; mem[8'h25] = 16'h2003;
        mem[8'h26] = 16'hC111; mem[8'h27] = 16'h5555;
        mem[8'h40] = 16'h3333; mem[8'h41] = 16'h3334;
        mem[8'h42] = 16'hC222; mem[8'h43] = 16'h4444;

        //          st  rd  rpc    cs addr   full instr    imm      pc     v
        vecs[0]  = '{0, 0, 32'h0,  0, 32'h00, 0, 16'h0,    16'h0,    32'h0,  0};
        vecs[1]  = '{0, 0, 32'h0,  1, 32'h00, 1, 16'h0,    16'h0,    32'h0,  0};
        vecs[2]  = '{0, 0, 32'h0,  1, 32'h01, 1, 16'h0,    16'h0,    32'h0,  0};
        vecs[3]  = '{0, 0, 32'h0,  1, 32'h20, 1, 16'h1940, 16'h0,    32'h20, 1};
        vecs[4]  = '{0, 0, 32'h0,  1, 32'h21, 0, 16'h0,    16'h0,    32'h0,  0};
        vecs[5]  = '{0, 0, 32'h0,  1, 32'h22, 1, 16'hC800, 16'h1234, 32'h21, 1};
        vecs[6]  = '{0, 0, 32'h0,  1, 32'h23, 1, 16'h2001, 16'h0,    32'h23, 1};
        vecs[7]  = '{1, 0, 32'h0,  1, 32'h24, 1, 16'h2001, 16'h0,    32'h23, 1};
        vecs[8]  = '{1, 0, 32'h0,  1, 32'h24, 1, 16'h2001, 16'h0,    32'h23, 1};
        vecs[9]  = '{1, 0, 32'h0,  1, 32'h24, 1, 16'h2001, 16'h0,    32'h23, 1};
        vecs[10] = '{0, 0, 32'h0,  1, 32'h24, 1, 16'h2002, 16'h0,    32'h24, 1};
        vecs[11] = '{0, 0, 32'h0,  1, 32'h25, 1, 16'h2003, 16'h0,    32'h25, 1};
        vecs[12] = '{0, 0, 32'h0,  1, 32'h26, 0, 16'h0,    16'h0,    32'h0,  0};
        vecs[13] = '{1, 1, 32'h40, 1, 32'h27, 0, 16'h0,    16'h0,    32'h0,  0};
        vecs[14] = '{0, 0, 32'h0,  1, 32'h40, 1, 16'h3333, 16'h0,    32'h40, 1};
        vecs[15] = '{0, 0, 32'h0,  1, 32'h41, 1, 16'h3334, 16'h0,    32'h41, 1};

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step(); step();
        chk_zero_outputs("reset");
        chk("reset.wr", 32'(mem_write), 0);
        chk("reset.wdata", 32'(mem_wdata), 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            stall = vecs[i].stall; redirect = vecs[i].redirect; redirect_pc = vecs[i].rpc;
            #1;
            chk($sformatf("v%0d.addr", i), mem_addr, vecs[i].addr);
            chk($sformatf("v%0d.cs", i), 32'(mem_cs), 32'(vecs[i].cs));
            chk($sformatf("v%0d.rd", i), 32'(mem_read), 32'(vecs[i].cs));
            chk($sformatf("v%0d.wr", i), 32'(mem_write), 0);
            step();
            chk($sformatf("v%0d.valid", i), 32'(if_id_valid), 32'(vecs[i].valid));
            if (vecs[i].full) begin
                chk($sformatf("v%0d.instr", i), 32'(if_id_instr), 32'(vecs[i].instr));
                chk($sformatf("v%0d.imm", i), 32'(if_id_imm), 32'(vecs[i].imm));
                chk($sformatf("v%0d.pc", i), if_id_pc, vecs[i].pc);
            end
        end
        stall = 1'b0; redirect = 1'b0;

        // Reset while in IMM: everything clears, vector reload repeats.
        chk("mid.addr42", mem_addr, 32'h42);
        step();                                 // C222 -> IMM
        chk("mid.bubble", 32'(if_id_valid), 0);
        chk("mid.addr43", mem_addr, 32'h43);
        rst = 1'b1;
        step();
        chk_zero_outputs("midrst");
        rst = 1'b0;
        // stall/redirect must be ignored during the reload
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        step();                                 // RESET -> VEC_HI
        chk("reload.addr_hi", mem_addr, 32'h0);
        chk("reload.cs", 32'(mem_cs), 1);
        step();
        chk("reload.addr_lo", mem_addr, 32'h1);
        step();
        stall = 1'b0; redirect = 1'b0;
        chk("reload.addr_fetch", mem_addr, 32'h20);
        step();
        chk("reload.instr", 32'(if_id_instr), 32'h1940);
        chk("reload.pc", if_id_pc, 32'h20);
        chk("reload.valid", 32'(if_id_valid), 1);
        chk("reload.imm", 32'(if_id_imm), 0);

        // Wrap-around: vector 0xFFFFFFFF.
        mem[8'h00] = 16'hFFFF; mem[8'h01] = 16'hFFFF; mem[8'hFF] = 16'h1111;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(); step(); step();
        chk("wrap.addr0", mem_addr, 32'hFFFF_FFFF);
        step();
        chk("wrap.pc", if_id_pc, 32'hFFFF_FFFF);
        chk("wrap.instr", 32'(if_id_instr), 32'h1111);
        chk("wrap.valid", 32'(if_id_valid), 1);
        chk("wrap.addr1", mem_addr, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
